// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: per-source result FIFOs drained onto a
// set of write ports in round-robin order, never writing one address twice per cycle.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NR_SOURCES     = 4,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NR_SOURCES-1:0]                src_valid_i,
  output logic [NR_SOURCES-1:0]                src_ready_o,
  input  logic [NR_SOURCES*5-1:0]              src_waddr_i,
  input  logic [NR_SOURCES*DATA_WIDTH-1:0]     src_wdata_i,
  output logic [NR_WRITE_PORTS-1:0]            we_o,
  output logic [NR_WRITE_PORTS*5-1:0]          waddr_o,
  output logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_o
);

  localparam int unsigned AW     = 5;
  localparam int unsigned SRC_W  = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1;
  localparam int unsigned PORT_W = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [AW-1:0]         addr_mem_q [NR_SOURCES][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [NR_SOURCES][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q   [NR_SOURCES];
  logic [PTR_W-1:0]      wr_ptr_q   [NR_SOURCES];
  logic [CNT_W-1:0]      count_q    [NR_SOURCES];
  logic [CNT_W-1:0]      count_d    [NR_SOURCES];
  logic [AW-1:0]         head_addr  [NR_SOURCES];
  logic [DATA_WIDTH-1:0] head_data  [NR_SOURCES];
  logic [NR_SOURCES-1:0] push;
  logic [NR_SOURCES-1:0] pop;
  logic [SRC_W-1:0]      rr_ptr_q;
  logic [SRC_W-1:0]      rr_ptr_d;

  logic [NR_WRITE_PORTS-1:0] gnt_we;
  logic [AW-1:0]             gnt_addr [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]     gnt_data [NR_WRITE_PORTS];

  // Zero-address results are handshaken but never enqueued.
  for (genvar s = 0; s < NR_SOURCES; s++) begin : g_src
    assign push[s]      = src_valid_i[s] & src_ready_o[s] & (src_waddr_i[s*AW +: AW] != '0);
    assign head_addr[s] = addr_mem_q[s][rd_ptr_q[s]];
    assign head_data[s] = data_mem_q[s][rd_ptr_q[s]];
    assign count_d[s]   = count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
  end

  // Round-robin scan from rr_ptr; a head colliding with an already granted address waits.
  always_comb begin
    int unsigned idx;
    int unsigned n_gnt;
    logic        conflict;
    idx      = 0;
    n_gnt    = 0;
    conflict = 1'b0;
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    gnt_we   = '0;
    for (int unsigned k = 0; k < NR_WRITE_PORTS; k++) begin
      gnt_addr[PORT_W'(k)] = '0;
      gnt_data[PORT_W'(k)] = '0;
    end
    for (int unsigned i = 0; i < NR_SOURCES; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NR_SOURCES) idx = idx - NR_SOURCES;
      conflict = 1'b0;
      for (int unsigned k = 0; k < NR_WRITE_PORTS; k++) begin
        if (gnt_we[PORT_W'(k)] && (gnt_addr[PORT_W'(k)] == head_addr[SRC_W'(idx)])) conflict = 1'b1;
      end
      if ((count_q[SRC_W'(idx)] != '0) && (n_gnt < NR_WRITE_PORTS) && !conflict) begin
        gnt_we[PORT_W'(n_gnt)]   = 1'b1;
        gnt_addr[PORT_W'(n_gnt)] = head_addr[SRC_W'(idx)];
        gnt_data[PORT_W'(n_gnt)] = head_data[SRC_W'(idx)];
        pop[SRC_W'(idx)]         = 1'b1;
        rr_ptr_d                 = (idx == NR_SOURCES - 1) ? '0 : SRC_W'(idx + 1);
        n_gnt                    = n_gnt + 1;
      end
    end
  end

  // FIFO storage needs no reset: pointers and counts define what is live.
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NR_SOURCES; s++) begin
      if (push[SRC_W'(s)]) begin
        addr_mem_q[SRC_W'(s)][wr_ptr_q[SRC_W'(s)]] <= src_waddr_i[s*AW +: AW];
        data_mem_q[SRC_W'(s)][wr_ptr_q[SRC_W'(s)]] <= src_wdata_i[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is registered from the next occupancy so it never sees a same-cycle pop combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < NR_SOURCES; s++) begin
        rd_ptr_q[SRC_W'(s)] <= '0;
        wr_ptr_q[SRC_W'(s)] <= '0;
        count_q[SRC_W'(s)]  <= '0;
      end
      src_ready_o <= '0;
      rr_ptr_q    <= '0;
      we_o        <= '0;
      waddr_o     <= '0;
      wdata_o     <= '0;
    end else begin
      for (int unsigned s = 0; s < NR_SOURCES; s++) begin
        if (push[SRC_W'(s)]) wr_ptr_q[SRC_W'(s)] <= wr_ptr_q[SRC_W'(s)] + PTR_W'(1);
        if (pop[SRC_W'(s)])  rd_ptr_q[SRC_W'(s)] <= rd_ptr_q[SRC_W'(s)] + PTR_W'(1);
        count_q[SRC_W'(s)]     <= count_d[SRC_W'(s)];
        src_ready_o[SRC_W'(s)] <= (count_d[SRC_W'(s)] != CNT_W'(FIFO_DEPTH));
      end
      rr_ptr_q <= rr_ptr_d;
      we_o     <= gnt_we;
      for (int unsigned k = 0; k < NR_WRITE_PORTS; k++) begin
        waddr_o[k*AW +: AW]                 <= gnt_addr[PORT_W'(k)];
        wdata_o[k*DATA_WIDTH +: DATA_WIDTH] <= gnt_data[PORT_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a 2-port instance for the main
// scenarios and a 1-port instance for source backpressure.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  // 2-write-port instance
  logic [3:0]   v;
  logic [3:0]   rdy;
  logic [19:0]  a;
  logic [127:0] d;
  logic [1:0]   we;
  logic [9:0]   wa;
  logic [63:0]  wd;

  // 1-write-port instance
  logic [3:0]   b_v;
  logic [3:0]   b_rdy;
  logic [19:0]  b_a;
  logic [127:0] b_d;
  logic [0:0]   b_we;
  logic [4:0]   b_wa;
  logic [31:0]  b_wd;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .NR_SOURCES(4), .NR_WRITE_PORTS(2), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .src_valid_i(v), .src_ready_o(rdy), .src_waddr_i(a),
    .src_wdata_i(d), .we_o(we), .waddr_o(wa), .wdata_o(wd)
  );

  regfile_wb_arbiter #(.DATA_WIDTH(32), .NR_SOURCES(4), .NR_WRITE_PORTS(1), .FIFO_DEPTH(2)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .src_valid_i(b_v), .src_ready_o(b_rdy), .src_waddr_i(b_a),
    .src_wdata_i(b_d), .we_o(b_we), .waddr_o(b_wa), .wdata_o(b_wd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic vld, input logic [4:0] adr, input logic [31:0] dat);
    v[s]          = vld;
    a[s*5 +: 5]   = adr;
    d[s*32 +: 32] = dat;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
  endtask

  logic [31:0] b3_data [3];
  logic [31:0] b3_got  [3];
  int          idx3;
  int          n3;
  logic        rdy_before;

  initial begin
    rst_i = 1'b1;
    v = '0; a = '0; d = '0;
    b_v = '0; b_a = '0; b_d = '0;
    b3_data[0] = 32'hA0; b3_data[1] = 32'hA1; b3_data[2] = 32'hA2;
    step();
    step();
    check("rst_we", 64'(we), 64'h0);
    check("rst_waddr", 64'(wa), 64'h0);
    check("rst_wdata", wd, 64'h0);
    check("rst_ready", 64'(rdy), 64'h0);
    rst_i = 1'b0;
    step();
    check("post_rst_ready", 64'(rdy), 64'hF);
    check("post_rst_ready_b", 64'(b_rdy), 64'hF);

    // Backpressure on source 3 while sources 0..2 hog the single write port
    b_v[2:0] = 3'b111;
    b_a = {5'd20, 5'd3, 5'd2, 5'd1};
    b_d[95:0] = {32'h33, 32'h22, 32'h11};
    idx3 = 0;
    n3   = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      b_v[3]      = (idx3 < 3);
      b_d[127:96] = b3_data[(idx3 < 3) ? idx3 : 2];
      rdy_before  = b_rdy[3];
      step();
      if (b_v[3] && rdy_before) idx3++;
      if (b_we[0] && b_wa == 5'd20) begin
        if (n3 < 3) b3_got[n3] = b_wd;
        n3++;
      end
      if (cyc == 1) begin
        check("bp_ready3_full", 64'(b_rdy[3]), 64'h0);
        check("bp_accepted2", 64'(idx3), 64'd2);
      end
      if (cyc == 3) check("bp_ready3_held", 64'(b_rdy[3]), 64'h0);
    end
    check("bp_count", 64'(n3), 64'd3);
    for (int i = 0; i < 3; i++) check($sformatf("bp_order%0d", i), 64'(b3_got[i]), 64'(b3_data[i]));
    b_v = '0;

    // Single write from source 1
    do_reset();
    set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    set_src(1, 1'b0, 5'd0, 32'h0);
    check("single_latency_we", 64'(we), 64'h0);
    step();
    check("single_we", 64'(we), 64'h1);
    check("single_waddr0", 64'(wa[4:0]), 64'd5);
    check("single_wdata0", 64'(wd[31:0]), 64'hDEADBEEF);
    check("single_port1_idle", 64'({wa[9:5], wd[63:32]}), 64'h0);
    step();
    check("single_done", 64'(we), 64'h0);

    // Zero register writes are accepted and dropped
    do_reset();
    set_src(0, 1'b1, 5'd0, 32'h123);
    step();
    set_src(0, 1'b0, 5'd0, 32'h0);
    check("zero_ready", 64'(rdy), 64'hF);
    step();
    check("zero_we_a", 64'(we), 64'h0);
    step();
    check("zero_we_b", 64'(we), 64'h0);

    // Address conflict between sources 0 and 2
    do_reset();
    set_src(0, 1'b1, 5'd7, 32'hAAAA);
    set_src(2, 1'b1, 5'd7, 32'hBBBB);
    step();
    set_src(0, 1'b0, 5'd0, 32'h0);
    set_src(2, 1'b0, 5'd0, 32'h0);
    step();
    check("conf_c1_we", 64'(we), 64'h1);
    check("conf_c1_addr", 64'(wa[4:0]), 64'd7);
    check("conf_c1_data", 64'(wd[31:0]), 64'hAAAA);
    step();
    check("conf_c2_we", 64'(we), 64'h1);
    check("conf_c2_data", 64'(wd[31:0]), 64'hBBBB);

    // rr_ptr is now 3: scan 3,0,1,2 puts source 3 on port 0, source 1 on port 1
    set_src(1, 1'b1, 5'd9,  32'h11);
    set_src(3, 1'b1, 5'd10, 32'h33);
    step();
    set_src(1, 1'b0, 5'd0, 32'h0);
    set_src(3, 1'b0, 5'd0, 32'h0);
    check("conf_c3_we", 64'(we), 64'h0);
    step();
    check("wrap_we", 64'(we), 64'h3);
    check("wrap_addr", 64'(wa), 64'({5'd9, 5'd10}));
    check("wrap_data", wd, {32'h11, 32'h33});

    // Fairness: all sources continuously valid
    do_reset();
    for (int s = 0; s < 4; s++) set_src(s, 1'b1, 5'(8 + s), 32'(32'h100 * s));
    step();
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("fair_we%0d", c), 64'(we), 64'h3);
      check($sformatf("fair_addr%0d", c), 64'(wa), (c % 2 == 0) ? 64'({5'd9, 5'd8}) : 64'({5'd11, 5'd10}));
    end

    // Mid-operation reset with results still buffered and inputs still valid
    rst_i = 1'b1;
    step();
    check("mrst_we", 64'(we), 64'h0);
    check("mrst_ready", 64'(rdy), 64'h0);
    rst_i = 1'b0;
    v = '0;
    step();
    check("mrst_ready_after", 64'(rdy), 64'hF);
    check("mrst_we_after", 64'(we), 64'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("mrst_drain%0d", c), 64'(we), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
